// File: rtl/t03_pkg.sv
// Shared types and encodings for the team-03 control sequencer: FSM states,
// immediate-type selects, opcodes and datapath select codes.
package t03_pkg;

   typedef enum logic [2:0] {
      ST_FETCH     = 3'd0,
      ST_DECODE    = 3'd1,
      ST_EXECUTE   = 3'd2,
      ST_MEM       = 3'd3,
      ST_WRITEBACK = 3'd4,
      ST_HALT      = 3'd7
   } state_e;

   // Must stay in step with the encoding expected by t03_imm_generator
   typedef enum logic [2:0] {
      IMM_I    = 3'd0,
      IMM_S    = 3'd1,
      IMM_SB   = 3'd2,
      IMM_U    = 3'd3,
      IMM_UJ   = 3'd4,
      IMM_NONE = 3'd7
   } imm_type_e;

   localparam logic [6:0] OPC_OP     = 7'b0110011;
   localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
   localparam logic [6:0] OPC_LOAD   = 7'b0000011;
   localparam logic [6:0] OPC_STORE  = 7'b0100011;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;
   localparam logic [6:0] OPC_JAL    = 7'b1101111;
   localparam logic [6:0] OPC_JALR   = 7'b1100111;
   localparam logic [6:0] OPC_LUI    = 7'b0110111;
   localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

   localparam logic [1:0] PC_SEL_PLUS4  = 2'd0;
   localparam logic [1:0] PC_SEL_PC_IMM = 2'd1;
   localparam logic [1:0] PC_SEL_RS1    = 2'd2;

   localparam logic [1:0] WB_SEL_ALU   = 2'd0;
   localparam logic [1:0] WB_SEL_MEM   = 2'd1;
   localparam logic [1:0] WB_SEL_PC4   = 2'd2;
   localparam logic [1:0] WB_SEL_IMM   = 2'd3;

   typedef struct packed {
      logic      valid;
      imm_type_e immType;
      logic      aluSrcB;
      logic [1:0] pcSel;
      logic [1:0] wbSel;
      logic      isLoad;
      logic      isStore;
      logic      isBranch;
      logic      regWrite;
   } decode_t;

endpackage

// File: rtl/t03_control_fsm_if.sv
// Instruction-bus and data-bus handshake bundle between the control sequencer
// (master) and the memory side (slave).
interface t03_control_fsm_if;

   logic [31:0] inst;
   logic        i_ack;
   logic        i_req;
   logic        d_ack;
   logic        d_ren;
   logic        d_wen;

   modport master (
      input  inst,
      input  i_ack,
      input  d_ack,
      output i_req,
      output d_ren,
      output d_wen
   );

   modport slave (
      output inst,
      output i_ack,
      output d_ack,
      input  i_req,
      input  d_ren,
      input  d_wen
   );

endinterface

// File: rtl/t03_opcode_decoder.sv
// Purely combinational RV32I opcode decoder; the sequencer registers its
// result during DECODE.
module t03_opcode_decoder
   import t03_pkg::*;
(
   input  logic [6:0] opcode_i,
   output decode_t    dec_o
);

   // Unknown opcodes fall through with valid low and a harmless NONE select
   always_comb begin
      dec_o          = '0;
      dec_o.immType  = IMM_NONE;
      dec_o.pcSel    = PC_SEL_PLUS4;
      dec_o.wbSel    = WB_SEL_ALU;
      case (opcode_i)
         OPC_OP: begin
            dec_o.valid    = 1'b1;
            dec_o.regWrite = 1'b1;
         end
         OPC_OP_IMM: begin
            dec_o.valid    = 1'b1;
            dec_o.immType  = IMM_I;
            dec_o.aluSrcB  = 1'b1;
            dec_o.regWrite = 1'b1;
         end
         OPC_LOAD: begin
            dec_o.valid    = 1'b1;
            dec_o.immType  = IMM_I;
            dec_o.aluSrcB  = 1'b1;
            dec_o.wbSel    = WB_SEL_MEM;
            dec_o.isLoad   = 1'b1;
            dec_o.regWrite = 1'b1;
         end
         OPC_STORE: begin
            dec_o.valid    = 1'b1;
            dec_o.immType  = IMM_S;
            dec_o.aluSrcB  = 1'b1;
            dec_o.isStore  = 1'b1;
         end
         OPC_BRANCH: begin
            dec_o.valid    = 1'b1;
            dec_o.immType  = IMM_SB;
            dec_o.isBranch = 1'b1;
         end
         OPC_JAL: begin
            dec_o.valid    = 1'b1;
            dec_o.immType  = IMM_UJ;
            dec_o.pcSel    = PC_SEL_PC_IMM;
            dec_o.wbSel    = WB_SEL_PC4;
            dec_o.regWrite = 1'b1;
         end
         OPC_JALR: begin
            dec_o.valid    = 1'b1;
            dec_o.immType  = IMM_I;
            dec_o.aluSrcB  = 1'b1;
            dec_o.pcSel    = PC_SEL_RS1;
            dec_o.wbSel    = WB_SEL_PC4;
            dec_o.regWrite = 1'b1;
         end
         OPC_LUI: begin
            dec_o.valid    = 1'b1;
            dec_o.immType  = IMM_U;
            dec_o.wbSel    = WB_SEL_IMM;
            dec_o.regWrite = 1'b1;
         end
         OPC_AUIPC: begin
            dec_o.valid    = 1'b1;
            dec_o.immType  = IMM_U;
            dec_o.aluSrcB  = 1'b1;
            dec_o.regWrite = 1'b1;
         end
         default: begin
            dec_o.valid    = 1'b0;
         end
      endcase
   end

endmodule

// File: rtl/t03_control_fsm.sv
// Multi-cycle control sequencer for the team-03 RV32I core: fetch, decode,
// execute, optional memory access, writeback, with a sticky illegal halt.
module t03_control_fsm
   import t03_pkg::*;
#(
   parameter bit RESET_HALT = 1'b0
) (
   input  logic                clk,
   input  logic                rst,
   t03_control_fsm_if.master   bus,
   input  logic                en,
   input  logic                branch_taken,
   output logic [31:0]         ir,
   output logic [2:0]          imm_type,
   output logic                alu_src_b,
   output logic [1:0]          pc_sel,
   output logic                pc_en,
   output logic                reg_wen,
   output logic [1:0]          wb_sel,
   output logic                illegal,
   output logic [2:0]          state_o
);

   localparam state_e RESET_STATE = RESET_HALT ? ST_HALT : ST_FETCH;

   state_e      state_q,     state_d;
   logic [31:0] ir_q,        ir_d;
   imm_type_e   immType_q,   immType_d;
   logic        aluSrcB_q,   aluSrcB_d;
   logic [1:0]  pcSel_q,     pcSel_d;
   logic [1:0]  wbSel_q,     wbSel_d;
   logic        isLoad_q,    isLoad_d;
   logic        isStore_q,   isStore_d;
   logic        isBranch_q,  isBranch_d;
   logic        regWrite_q,  regWrite_d;
   logic        illegal_q,   illegal_d;

   decode_t     dec;

   t03_opcode_decoder u_decoder (
      .opcode_i (ir_q[6:0]),
      .dec_o    (dec)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= RESET_STATE;
         ir_q       <= '0;
         immType_q  <= IMM_I;
         aluSrcB_q  <= 1'b0;
         pcSel_q    <= '0;
         wbSel_q    <= '0;
         isLoad_q   <= 1'b0;
         isStore_q  <= 1'b0;
         isBranch_q <= 1'b0;
         regWrite_q <= 1'b0;
         illegal_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         ir_q       <= ir_d;
         immType_q  <= immType_d;
         aluSrcB_q  <= aluSrcB_d;
         pcSel_q    <= pcSel_d;
         wbSel_q    <= wbSel_d;
         isLoad_q   <= isLoad_d;
         isStore_q  <= isStore_d;
         isBranch_q <= isBranch_d;
         regWrite_q <= regWrite_d;
         illegal_q  <= illegal_d;
      end
   end

   // Decode fields are captured once in DECODE and held until the next DECODE,
   // except the branch target select, which is resolved on leaving EXECUTE.
   always_comb begin
      state_d    = state_q;
      ir_d       = ir_q;
      immType_d  = immType_q;
      aluSrcB_d  = aluSrcB_q;
      pcSel_d    = pcSel_q;
      wbSel_d    = wbSel_q;
      isLoad_d   = isLoad_q;
      isStore_d  = isStore_q;
      isBranch_d = isBranch_q;
      regWrite_d = regWrite_q;
      illegal_d  = illegal_q;
      case (state_q)
         ST_FETCH: begin
            if (en && bus.i_ack) begin
               ir_d    = bus.inst;
               state_d = ST_DECODE;
            end
         end
         ST_DECODE: begin
            immType_d  = dec.immType;
            aluSrcB_d  = dec.aluSrcB;
            pcSel_d    = dec.pcSel;
            wbSel_d    = dec.wbSel;
            isLoad_d   = dec.isLoad;
            isStore_d  = dec.isStore;
            isBranch_d = dec.isBranch;
            regWrite_d = dec.regWrite;
            if (!dec.valid) begin
               illegal_d = 1'b1;
               state_d   = ST_HALT;
            end else begin
               state_d   = ST_EXECUTE;
            end
         end
         ST_EXECUTE: begin
            if (isBranch_q) begin
               pcSel_d = branch_taken ? PC_SEL_PC_IMM : PC_SEL_PLUS4;
            end
            state_d = (isLoad_q || isStore_q) ? ST_MEM : ST_WRITEBACK;
         end
         ST_MEM: begin
            if (bus.d_ack) begin
               state_d = ST_WRITEBACK;
            end
         end
         ST_WRITEBACK: begin
            state_d = ST_FETCH;
         end
         ST_HALT: begin
            state_d = ST_HALT;
         end
         default: begin
            state_d = ST_HALT;
         end
      endcase
   end

   // Strobes depend on state alone (plus en for the fetch request), so an
   // asynchronous reset drops them in the same cycle; rst also masks i_req
   // while the FSM is held in FETCH by reset.
   always_comb begin
      bus.i_req = 1'b0;
      bus.d_ren = 1'b0;
      bus.d_wen = 1'b0;
      pc_en     = 1'b0;
      reg_wen   = 1'b0;
      case (state_q)
         ST_FETCH:     bus.i_req = en && !rst;
         ST_MEM: begin
            bus.d_ren = isLoad_q;
            bus.d_wen = isStore_q;
         end
         ST_WRITEBACK: begin
            pc_en   = 1'b1;
            reg_wen = regWrite_q;
         end
         default: begin
            bus.i_req = 1'b0;
         end
      endcase
   end

   assign ir        = ir_q;
   assign imm_type  = immType_q;
   assign alu_src_b = aluSrcB_q;
   assign pc_sel    = pcSel_q;
   assign wb_sel    = wbSel_q;
   assign illegal   = illegal_q;
   assign state_o   = state_q;

endmodule

// File: tb/tb_t03_control_fsm.sv
// Directed self-checking bench for t03_control_fsm: ADD, LW with delayed ack,
// BEQ taken/not-taken, illegal halt, reset mid-store, and en gating with JAL.
module tb_t03_control_fsm;

   logic        clk;
   logic        rst;
   logic        en;
   logic        branchTaken;
   logic [31:0] ir;
   logic [2:0]  immType;
   logic        aluSrcB;
   logic [1:0]  pcSel;
   logic        pcEn;
   logic        regWen;
   logic [1:0]  wbSel;
   logic        illegal;
   logic [2:0]  stateO;

   int testsRun  = 0;
   int failCount = 0;

   t03_control_fsm_if bus ();

   t03_control_fsm #(.RESET_HALT(1'b0)) dut (
      .clk          (clk),
      .rst          (rst),
      .bus          (bus.master),
      .en           (en),
      .branch_taken (branchTaken),
      .ir           (ir),
      .imm_type     (immType),
      .alu_src_b    (aluSrcB),
      .pc_sel       (pcSel),
      .pc_en        (pcEn),
      .reg_wen      (regWen),
      .wb_sel       (wbSel),
      .illegal      (illegal),
      .state_o      (stateO)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation did not finish, observed timeout required completion");
      $fatal(1, "[TB] watchdog expired");
   end

   // Inputs change #1 after a rising edge and outputs are sampled there too
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic applyStimulus(input logic [31:0] instWord, input logic iAck,
                                input logic dAck, input logic taken);
      bus.inst    = instWord;
      bus.i_ack   = iAck;
      bus.d_ack   = dAck;
      branchTaken = taken;
   endtask

   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      testsRun++;
      assert (observed === expected) else begin
         failCount++;
         $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
      end
   endtask

   // Main directed sequence; cycle numbers count from the FETCH cycle
   initial begin
      int strobeHits;
      rst = 1'b1;
      en  = 1'b1;
      applyStimulus(32'h0, 1'b0, 1'b0, 1'b0);
      repeat (2) @(posedge clk);
      #1;
      checkOutput("reset_state", stateO, 32'd0);
      checkOutput("reset_ireq", bus.i_req, 32'd0);
      checkOutput("reset_ir", ir, 32'd0);
      checkOutput("reset_imm", immType, 32'd0);
      checkOutput("reset_illegal", illegal, 32'd0);
      rst = 1'b0;
      #1;

      // ADD with same-cycle ack
      checkOutput("add_c1_ireq", bus.i_req, 32'd1);
      applyStimulus(32'h002081B3, 1'b1, 1'b0, 1'b0);
      tick();
      applyStimulus(32'h002081B3, 1'b0, 1'b0, 1'b0);
      checkOutput("add_c2_state", stateO, 32'd1);
      checkOutput("add_c2_ir", ir, 32'h002081B3);
      checkOutput("add_c2_regwen", regWen, 32'd0);
      tick();
      checkOutput("add_c3_imm", immType, 32'd7);
      checkOutput("add_c3_pcen", pcEn, 32'd0);
      tick();
      checkOutput("add_c4_regwen", regWen, 32'd1);
      checkOutput("add_c4_pcen", pcEn, 32'd1);
      checkOutput("add_c4_pcsel", pcSel, 32'd0);
      checkOutput("add_c4_wbsel", wbSel, 32'd0);
      tick();
      checkOutput("add_c5_ireq", bus.i_req, 32'd1);
      checkOutput("add_c5_regwen", regWen, 32'd0);

      // LW with d_ack three cycles late
      applyStimulus(32'h0040A103, 1'b1, 1'b0, 1'b0);
      tick();
      applyStimulus(32'h0040A103, 1'b0, 1'b0, 1'b0);
      tick();
      checkOutput("lw_imm", immType, 32'd0);
      checkOutput("lw_wbsel", wbSel, 32'd1);
      checkOutput("lw_exec_dren", bus.d_ren, 32'd0);
      tick();
      for (int k = 0; k < 4; k++) begin
         checkOutput("lw_mem_dren", bus.d_ren, 32'd1);
         checkOutput("lw_mem_regwen", regWen, 32'd0);
         if (k == 3) bus.d_ack = 1'b1;
         tick();
      end
      bus.d_ack = 1'b0;
      checkOutput("lw_wb_dren", bus.d_ren, 32'd0);
      checkOutput("lw_wb_regwen", regWen, 32'd1);
      tick();
      checkOutput("lw_after_regwen", regWen, 32'd0);
      checkOutput("lw_after_state", stateO, 32'd0);

      // BEQ taken then not taken
      for (int run = 0; run < 2; run++) begin
         applyStimulus(32'h00208463, 1'b1, 1'b0, (run == 0));
         tick();
         bus.i_ack = 1'b0;
         tick();
         checkOutput("beq_imm", immType, 32'd2);
         tick();
         checkOutput("beq_pcen", pcEn, 32'd1);
         checkOutput("beq_regwen", regWen, 32'd0);
         checkOutput(run == 0 ? "beq_taken_pcsel" : "beq_nottaken_pcsel",
                     pcSel, (run == 0) ? 32'd1 : 32'd0);
         tick();
      end

      // Illegal opcode halts and ignores every bus input
      applyStimulus(32'h0000007F, 1'b1, 1'b0, 1'b0);
      tick();
      bus.i_ack = 1'b0;
      checkOutput("ill_decode_flag", illegal, 32'd0);
      tick();
      checkOutput("ill_flag", illegal, 32'd1);
      checkOutput("ill_state", stateO, 32'd7);
      applyStimulus(32'h002081B3, 1'b1, 1'b1, 1'b1);
      strobeHits = 0;
      for (int k = 0; k < 20; k++) begin
         if (bus.i_req || bus.d_ren || bus.d_wen || pcEn || regWen) strobeHits++;
         tick();
      end
      applyStimulus(32'h0, 1'b0, 1'b0, 1'b0);
      checkOutput("ill_no_strobes", strobeHits, 32'd0);
      checkOutput("ill_still_halt", stateO, 32'd7);
      rst = 1'b1;
      #1;
      checkOutput("ill_rst_clears", illegal, 32'd0);
      tick();
      rst = 1'b0;
      #1;
      checkOutput("ill_ireq_resume", bus.i_req, 32'd1);

      // SW interrupted by reset while in MEM
      applyStimulus(32'h0020A223, 1'b1, 1'b0, 1'b0);
      tick();
      bus.i_ack = 1'b0;
      tick();
      tick();
      checkOutput("sw_mem_dwen", bus.d_wen, 32'd1);
      checkOutput("sw_mem_imm", immType, 32'd1);
      rst = 1'b1;
      #1;
      checkOutput("sw_rst_dwen", bus.d_wen, 32'd0);
      checkOutput("sw_rst_pcen", pcEn, 32'd0);
      checkOutput("sw_rst_regwen", regWen, 32'd0);
      tick();
      checkOutput("sw_rst_hold_pcen", pcEn, 32'd0);

      // en low across reset release, then JAL with en dropped mid-instruction
      en = 1'b0;
      rst = 1'b0;
      #1;
      checkOutput("sw_restart_state", stateO, 32'd0);
      checkOutput("sw_restart_ir", ir, 32'd0);
      tick();
      checkOutput("en0_ireq", bus.i_req, 32'd0);
      en = 1'b1;
      tick();
      checkOutput("en1_ireq", bus.i_req, 32'd1);
      applyStimulus(32'h0080006F, 1'b1, 1'b0, 1'b0);
      tick();
      bus.i_ack = 1'b0;
      en = 1'b0;
      tick();
      checkOutput("jal_imm", immType, 32'd4);
      checkOutput("jal_wbsel", wbSel, 32'd2);
      checkOutput("jal_pcsel", pcSel, 32'd1);
      tick();
      checkOutput("jal_wb_regwen", regWen, 32'd1);
      checkOutput("jal_wb_pcen", pcEn, 32'd1);
      tick();
      checkOutput("jal_en0_ireq", bus.i_req, 32'd0);
      checkOutput("jal_en0_state", stateO, 32'd0);

      $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
      $finish;
   end

endmodule
